tx_burst_sequencer: RTL and testbench

- Sequences the acoustic transmit path by generating a gated square-wave carrier burst of a programmed length, followed by a guard interval.
- Sits between the control logic, which issues start/abort and configuration, and the output register stage that drives the transducer driver.
- Owns all timing of when the transmit datapath is enabled.

---
 rtl/tx_burst_sequencer.sv | 132 +++++++++++++
 tb/tb_tx_burst_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_burst_sequencer.sv
// Transmit burst sequencer: gated square-wave carrier burst followed by a guard interval.
// Define BURST_REPEAT_EN to add the repeat_cnt port for multi-burst sequences.
module tx_burst_sequencer #(
  parameter int CNT_W = 16,
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] half_period,
  input  logic [CNT_W-1:0] burst_cycles,
  input  logic [CNT_W-1:0] guard_ticks,
`ifdef BURST_REPEAT_EN
  input  logic [REP_W-1:0] repeat_cnt,
`endif
  output logic             busy,
  output logic             tx_en,
  output logic             tx_out,
  output logic             burst_done,
  output logic             all_done
);

  typedef enum logic [1:0] {IDLE, BURST, GUARD} state_t;

  state_t           state;
  // Latched terminal counts (value minus one, zero inputs clamped to one).
  logic [CNT_W-1:0] h_last;
  logic [CNT_W-1:0] c_last;
  logic [CNT_W-1:0] g_last;
  logic [CNT_W-1:0] half_cnt;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] guard_cnt;
  logic [REP_W-1:0] rep_left;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      h_last     <= '0;
      c_last     <= '0;
      g_last     <= '0;
      half_cnt   <= '0;
      cyc_cnt    <= '0;
      guard_cnt  <= '0;
      rep_left   <= '0;
      busy       <= 1'b0;
      tx_en      <= 1'b0;
      tx_out     <= 1'b0;
      burst_done <= 1'b0;
      all_done   <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      all_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort && (burst_cycles != '0)) begin
            h_last    <= (half_period == '0) ? '0 : half_period - CNT_W'(1);
            c_last    <= burst_cycles - CNT_W'(1);
            g_last    <= (guard_ticks == '0) ? '0 : guard_ticks - CNT_W'(1);
`ifdef BURST_REPEAT_EN
            rep_left  <= (repeat_cnt == '0) ? '0 : repeat_cnt - REP_W'(1);
`else
            rep_left  <= '0;
`endif
            half_cnt  <= '0;
            cyc_cnt   <= '0;
            guard_cnt <= '0;
            state     <= BURST;
            busy      <= 1'b1;
            tx_en     <= 1'b1;
            tx_out    <= 1'b1;
          end
        end
        BURST: begin
          if (abort) begin
            state  <= IDLE;
            busy   <= 1'b0;
            tx_en  <= 1'b0;
            tx_out <= 1'b0;
          end else if (half_cnt == h_last) begin
            half_cnt <= '0;
            if (tx_out) begin
              tx_out <= 1'b0;
            end else if (cyc_cnt == c_last) begin
              // Low half of the final carrier cycle just ended.
              state      <= GUARD;
              tx_en      <= 1'b0;
              tx_out     <= 1'b0;
              burst_done <= 1'b1;
              guard_cnt  <= '0;
            end else begin
              cyc_cnt <= cyc_cnt + CNT_W'(1);
              tx_out  <= 1'b1;
            end
          end else begin
            half_cnt <= half_cnt + CNT_W'(1);
          end
        end
        GUARD: begin
          if (abort) begin
            state  <= IDLE;
            busy   <= 1'b0;
            tx_en  <= 1'b0;
            tx_out <= 1'b0;
          end else if (guard_cnt == g_last) begin
            if (rep_left != '0) begin
              rep_left <= rep_left - REP_W'(1);
              half_cnt <= '0;
              cyc_cnt  <= '0;
              state    <= BURST;
              tx_en    <= 1'b1;
              tx_out   <= 1'b1;
            end else begin
              state    <= IDLE;
              busy     <= 1'b0;
              all_done <= 1'b1;
            end
          end else begin
            guard_cnt <= guard_cnt + CNT_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          tx_en  <= 1'b0;
          tx_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_burst_sequencer.sv
// Directed bench for tx_burst_sequencer; repeat checks run when BURST_REPEAT_EN is defined.
module tb_tx_burst_sequencer;

  localparam int CNT_W = 16;
  localparam int REP_W = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] half_period;
  logic [CNT_W-1:0] burst_cycles;
  logic [CNT_W-1:0] guard_ticks;
  logic [REP_W-1:0] repeat_cnt;
  logic             busy;
  logic             tx_en;
  logic             tx_out;
  logic             burst_done;
  logic             all_done;

  int total;
  int bad;

  tx_burst_sequencer #(.CNT_W(CNT_W), .REP_W(REP_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .half_period  (half_period),
    .burst_cycles (burst_cycles),
    .guard_ticks  (guard_ticks),
`ifdef BURST_REPEAT_EN
    .repeat_cnt   (repeat_cnt),
`endif
    .busy         (busy),
    .tx_en        (tx_en),
    .tx_out       (tx_out),
    .burst_done   (burst_done),
    .all_done     (all_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_busy, input logic e_en,
                          input logic e_out, input logic e_bd, input logic e_ad);
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".tx_en"}, 32'(tx_en), 32'(e_en));
    chk({tag, ".tx_out"}, 32'(tx_out), 32'(e_out));
    chk({tag, ".burst_done"}, 32'(burst_done), 32'(e_bd));
    chk({tag, ".all_done"}, 32'(all_done), 32'(e_ad));
  endtask

  // H=2, C=3, G=4 sequence. Called at the negedge of cycle N; returns at N+17.
  // inject>0 pulses a competing start in cycle N+inject.
  task automatic run_basic(input string tag, input int inject);
    half_period  = 16'd2;
    burst_cycles = 16'd3;
    guard_ticks  = 16'd4;
    start        = 1'b1;
    step();
    for (int k = 1; k <= 17; k++) begin
      logic e_en;
      logic e_out;
      start        = 1'b0;
      half_period  = 16'd2;
      burst_cycles = 16'd3;
      e_en  = (k <= 12);
      e_out = e_en && (((k - 1) % 4) < 2);
      chk_outs($sformatf("%s.k%0d", tag, k), (k <= 16), e_en, e_out, (k == 13), (k == 17));
      $display("%s cycle N+%0d busy=%0b tx_en=%0b tx_out=%0b bd=%0b ad=%0b",
               tag, k, busy, tx_en, tx_out, burst_done, all_done);
      if (k == inject) begin
        start        = 1'b1;
        half_period  = 16'd1;
        burst_cycles = 16'd1;
      end
      if (k < 17) step();
    end
  endtask

  initial begin
    logic seen;
    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    half_period  = '0;
    burst_cycles = '0;
    guard_ticks  = '0;
    repeat_cnt   = '0;
    step();
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("reset busy=%0b tx_en=%0b", busy, tx_en);
    rst_n = 1'b1;
    step();
    step();

    run_basic("basic", 0);
    step();
    chk_outs("basic.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Competing start during BURST must not disturb the sequence.
    run_basic("ignore", 3);
    start = 1'b0;
    step();
    chk_outs("ignore.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Abort at N+5.
    half_period  = 16'd2;
    burst_cycles = 16'd3;
    guard_ticks  = 16'd4;
    start        = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      start = 1'b0;
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_outs("abort.n6", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("abort N+6 busy=%0b tx_en=%0b tx_out=%0b", busy, tx_en, tx_out);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      seen = seen | burst_done | all_done | busy;
    end
    chk("abort.no_pulse", 32'(seen), 32'd0);

    // Zero half_period / guard_ticks, C=1.
    half_period  = 16'd0;
    burst_cycles = 16'd1;
    guard_ticks  = 16'd0;
    start        = 1'b1;
    step();
    start = 1'b0;
    chk_outs("zero.n1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_outs("zero.n2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk_outs("zero.n3", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk_outs("zero.n4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    $display("zero N+4 all_done=%0b busy=%0b", all_done, busy);
    step();

    // burst_cycles == 0 is a no-op.
    half_period  = 16'd2;
    burst_cycles = 16'd0;
    guard_ticks  = 16'd2;
    start        = 1'b1;
    seen         = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      start = 1'b0;
      seen  = seen | busy | tx_en | all_done | burst_done;
    end
    chk("c0.no_response", 32'(seen), 32'd0);
    $display("c0 no_response seen=%0b", seen);

    // Simultaneous start and abort in IDLE.
    burst_cycles = 16'd3;
    start        = 1'b1;
    abort        = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk_outs("simul.n1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("simul.n2.busy", 32'(busy), 32'd0);
    $display("simul busy=%0b tx_en=%0b", busy, tx_en);

    // Back-to-back: start in the all_done cycle.
    run_basic("b2b_a", 0);
    half_period  = 16'd2;
    burst_cycles = 16'd3;
    guard_ticks  = 16'd4;
    start        = 1'b1;
    step();
    start = 1'b0;
    chk_outs("b2b.n18", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    $display("b2b N+18 busy=%0b tx_en=%0b tx_out=%0b", busy, tx_en, tx_out);
    for (int k = 0; k < 20; k++) step();

    // Asynchronous reset mid-burst at N+3.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("rst.pre.busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_outs("rst.async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("rst async busy=%0b tx_en=%0b tx_out=%0b", busy, tx_en, tx_out);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk_outs("rst.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef BURST_REPEAT_EN
    // repeat_cnt=2, H=1, C=2, G=3.
    half_period  = 16'd1;
    burst_cycles = 16'd2;
    guard_ticks  = 16'd3;
    repeat_cnt   = 8'd2;
    start        = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      logic e_en;
      int   pos;
      e_en = (k <= 4) || (k >= 8 && k <= 11);
      pos  = (k <= 4) ? k - 1 : k - 8;
      chk_outs($sformatf("rep.k%0d", k), (k <= 14), e_en, e_en && (pos % 2 == 0),
               (k == 5) || (k == 12), (k == 15));
      $display("rep cycle N+%0d busy=%0b tx_en=%0b tx_out=%0b bd=%0b ad=%0b",
               k, busy, tx_en, tx_out, burst_done, all_done);
      if (k < 15) step();
    end
    step();
    // repeat_cnt=0 behaves as a single burst.
    repeat_cnt = 8'd0;
    start      = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      logic e_en;
      e_en = (k <= 4);
      chk_outs($sformatf("rep0.k%0d", k), (k <= 7), e_en, e_en && ((k % 2) == 1),
               (k == 5), (k == 8));
      if (k < 8) step();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
